// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory-side end of the system bus request/response
// protocol. Accepts line reads and 8-beat write bursts into an internal line
// store and returns read lines as 8 acknowledged 64-bit beats.
// Tag layout: [12] direction (1 = read, 0 = write), [11:8] target type
// (4'h1 = memory), [7:0] id.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_LINES      = 1024,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
    localparam int LINE_BITS = $clog2(MEM_LINES);
    localparam int ADDR_W    = LINE_BITS + 3;
    localparam int CNT_W     = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        LAT   = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Word-addressed line store: {line index, beat}
    logic [BUS_DATA_WIDTH-1:0] mem [0:(MEM_LINES*8)-1];

    state_t                    state, state_nx;
    logic [CNT_W-1:0]          lat_cnt, lat_cnt_nx;
    logic [2:0]                beat, beat_nx;
    logic [LINE_BITS-1:0]      line_idx, line_idx_nx;
    logic [BUS_TAG_WIDTH-1:0]  tag, tag_nx;
    logic                      reqack_nx;
    logic                      respcyc_nx;
    logic [BUS_DATA_WIDTH-1:0] resp_nx;
    logic [BUS_TAG_WIDTH-1:0]  resptag_nx;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_waddr;
    logic [2:0]                rd_beat;
    logic [BUS_DATA_WIDTH-1:0] rd_word;
    logic                      is_mem;

    assign is_mem  = (tag[11:8] == SYSBUS_MEMORY);
    // In LAT the first beat is fetched; in RESP the beat after the current one
    assign rd_beat = (state == RESP) ? 3'(beat + 3'd1) : 3'd0;
    assign rd_word = mem[{line_idx, rd_beat}];

    // Next-state, next-output and store-write decode
    always_comb begin
        state_nx    = state;
        lat_cnt_nx  = lat_cnt;
        beat_nx     = beat;
        line_idx_nx = line_idx;
        tag_nx      = tag;
        reqack_nx   = 1'b0;
        respcyc_nx  = bus_respcyc;
        resp_nx     = bus_resp;
        resptag_nx  = bus_resptag;
        mem_we      = 1'b0;
        mem_waddr   = {line_idx, beat};
        case (state)
            IDLE: begin
                if (bus_reqcyc) begin
                    reqack_nx   = 1'b1;
                    line_idx_nx = bus_req[6+LINE_BITS-1:6];
                    tag_nx      = bus_reqtag;
                    if (bus_reqtag[12] == SYSBUS_READ) begin
                        state_nx   = LAT;
                        lat_cnt_nx = CNT_W'(READ_LATENCY);
                    end else begin
                        state_nx = WDATA;
                        beat_nx  = 3'd0;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WDATA: begin
                if (bus_reqcyc) begin
                    reqack_nx = 1'b1;
                    mem_we    = is_mem;
                    if (beat == 3'd7) begin
                        state_nx = IDLE;
                        beat_nx  = 3'd0;
                    end else begin
                        beat_nx = 3'(beat + 3'd1);
                    end
                end else begin
                    state_nx = WDATA;
                end
            end
            LAT: begin
                // The edge that would take the counter to zero launches beat 0
                if (lat_cnt <= CNT_W'(1)) begin
                    state_nx   = RESP;
                    lat_cnt_nx = '0;
                    beat_nx    = 3'd0;
                    respcyc_nx = 1'b1;
                    resp_nx    = is_mem ? rd_word : '0;
                    resptag_nx = tag;
                end else begin
                    lat_cnt_nx = CNT_W'(lat_cnt - CNT_W'(1));
                end
            end
            RESP: begin
                if (bus_respack) begin
                    if (beat == 3'd7) begin
                        state_nx   = IDLE;
                        beat_nx    = 3'd0;
                        respcyc_nx = 1'b0;
                        resp_nx    = '0;
                        resptag_nx = '0;
                    end else begin
                        beat_nx = 3'(beat + 3'd1);
                        resp_nx = is_mem ? rd_word : '0;
                    end
                end else begin
                    state_nx = RESP;
                end
            end
            default: begin
                state_nx   = IDLE;
                beat_nx    = 3'd0;
                lat_cnt_nx = '0;
                respcyc_nx = 1'b0;
                resp_nx    = '0;
                resptag_nx = '0;
            end
        endcase
    end

    // State, counters and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            beat        <= 3'd0;
            line_idx    <= '0;
            tag         <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            state       <= state_nx;
            lat_cnt     <= lat_cnt_nx;
            beat        <= beat_nx;
            line_idx    <= line_idx_nx;
            tag         <= tag_nx;
            bus_reqack  <= reqack_nx;
            bus_respcyc <= respcyc_nx;
            bus_resp    <= resp_nx;
            bus_resptag <= resptag_nx;
        end
    end

    // Line store write port; contents survive reset, writes are blocked during it
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= bus_req;
        end
    end

endmodule

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the system bus: it is the far end of the request/response protocol driven by the core's fetch initiator. It accepts line-sized read and write requests, returns 64-byte lines as 8 beats of 64 bits with per-beat acknowledgement, and absorbs 8-beat write bursts into an internal line store. It serves as the DRAM model in bench and simulation builds and as the template for the real memory controller front end.

## Interface
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp
- BUS_TAG_WIDTH, 13, width of request/response tags
- MEM_LINES, 1024, lines in the store (power of two); line = 8 × BUS_DATA_WIDTH
- READ_LATENCY, 4, idle cycles between request ack and first read beat (≥1)

- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- bus_reqcyc  in  1  request/write-data beat valid
- bus_req  in  BUS_DATA_WIDTH  byte address on the request beat; write data on burst beats
- bus_reqtag  in  BUS_TAG_WIDTH  [12] = `SYSBUS_READ/`SYSBUS_WRITE, [11:8] = type (`SYSBUS_MEMORY etc.), [7:0] = id
- bus_reqack  out  1  one-cycle pulse per accepted request or write beat
- bus_respcyc  out  1  response beat valid
- bus_respack  in  1  initiator consumed current beat
- bus_resp  out  BUS_DATA_WIDTH  read data beat
- bus_resptag  out  BUS_TAG_WIDTH  tag of the request being answered

## Operation
- States: IDLE, WDATA, LAT, RESP.
- IDLE: edge with bus_reqcyc=1 captures bus_req, bus_reqtag; line index = bus_req[6+log2(MEM_LINES)-1:6]; bits [5:0] ignored; higher bits wrap modulo MEM_LINES.
  - tag[12]=read → LAT, latency counter = READ_LATENCY.
  - tag[12]=write → WDATA, beat counter = 0.
- WDATA: each edge with bus_reqcyc=1 writes bus_req to word beat of the line, beat+1; after beat 7 → IDLE. Edges with bus_reqcyc=0 wait indefinitely.
- LAT: counter decrements each cycle; at 0 → RESP, beat = 0.
- RESP: bus_respcyc=1, bus_resp = line word[beat], bus_resptag = captured tag. Edge with bus_respack=1 advances beat; after beat 7 is acked → IDLE. bus_respack=0 holds beat, data and tag stable.
- Type field ≠ `SYSBUS_MEMORY: request still acked; reads return 8 beats of zero; write beats acked and discarded.
- bus_respack outside RESP is ignored; bus_reqcyc in LAT/RESP is ignored (not acked; initiator must hold or retry).
- Store is not cleared by reset; unwritten lines read as X in simulation. Write then read of same line returns new data (no hazard: write completes before IDLE).

## Timing
- Reset: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, state IDLE, counters 0. Reset mid-burst aborts: beats already written stay written; remainder dropped.
- All outputs registered.
- Request accepted at edge T → bus_reqack=1 for the cycle after T only.
- Write beat consumed at edge T → bus_reqack=1 for the cycle after T; back-to-back beats give a continuous ack run.
- Read: accepted at edge T; bus_respcyc first high in cycle T+1+READ_LATENCY. With bus_respack held high, 8 beats occupy 8 consecutive cycles; bus_respcyc drops the cycle after beat 7's ack edge.
- Earliest next request acceptance: the edge at which state is IDLE again (cycle after last beat/last ack).

## Test plan
- Write then read: write tag, addr 0x1000, beats 0x11..0x88 → 8 acks; read 0x1000 with READ_LATENCY=4 → bus_respcyc first high 5 cycles after accept edge, beats 0x11..0x88 in order, resptag = request tag.
- Backpressure: during read, drop bus_respack for 3 cycles on beat 2 → bus_resp holds beat 2 value for those cycles, no beat skipped or duplicated, total 8 beats.
- Alignment/wrap: write to 0x1028 then read 0x1000 and 0x1000+MEM_LINES×64 → both return the 0x1028 write data.
- Non-memory type: read with type ≠ `SYSBUS_MEMORY → ack, 8 beats of 0x0; write burst to same → 8 acks, store unchanged.
- Reset mid-operation: assert reset during RESP beat 3 → next cycle all outputs 0, state IDLE; new read completes normally.
- Write burst with gaps: bus_reqcyc toggled 1/0 → exactly 8 acks, one per high edge, correct word placement.
